// File: rtl/count_sequencer_if.sv
// Host command / status bundle for count_sequencer; the host is the master, the sequencer the slave.
// Pure wiring, no latency; cmd_valid/cmd_ready form the only handshake.
interface count_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] limit;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc_pulse;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, limit, auto_reload,
        input  cmd_ready, count, busy, tc_pulse, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, limit, auto_reload,
        output cmd_ready, count, busy, tc_pulse, done
    );
endinterface

// File: rtl/count_sequencer.sv
// Command-driven up-counter controller: start/pause/stop/load, terminal detect, optional auto-reload.
// Latency: count moves one negedge after the accepting edge; done/tc_pulse one negedge after count==limit.
// Backpressure: cmd_ready drops only for the single DONE cycle; commands are otherwise always accepted.
module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    count_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_PAUSE = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             cmd_ready;
    logic             accept;

    assign cmd_ready = (state_q != DONE);
    assign accept    = bus.cmd_valid & cmd_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_START: begin
                            state_d  = RUN;
                            limit_d  = bus.limit;
                            reload_d = bus.auto_reload;
                        end
                        OP_LOAD: count_d = bus.cmd_data;
                        OP_STOP: count_d = '0;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // An accepted PAUSE/STOP/LOAD takes the place of this edge's increment and terminal check.
                if (accept && bus.cmd_op == OP_PAUSE) begin
                    state_d = PAUSE;
                end else if (accept && bus.cmd_op == OP_STOP) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (accept && bus.cmd_op == OP_LOAD) begin
                    count_d = bus.cmd_data;
                end else if (count_q == limit_q) begin
                    if (reload_q) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            PAUSE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_START: state_d = RUN;
                        OP_STOP: begin
                            state_d = IDLE;
                            count_d = '0;
                        end
                        OP_LOAD: count_d = bus.cmd_data;
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            limit_q  <= '0;
            reload_q <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.count     = count_q;
    assign bus.busy      = (state_q == RUN) || (state_q == PAUSE);
    assign bus.done      = (state_q == DONE);
    assign bus.tc_pulse  = tc_q;
endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: inputs change just after posedge, outputs sampled at posedge,
// so every observation sits half a cycle after the negedge that produced it.
module tb_count_sequencer;
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_PAUSE = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    logic clk   = 1'b1;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    count_sequencer_if #(.WIDTH(4)) bus ();

    count_sequencer #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // One command presented for exactly one negedge; limit/auto_reload are then scrambled
    // so any late re-latching of them would show up.
    task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [3:0] lim,
                        input logic ar);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_data    = data;
        bus.limit       = lim;
        bus.auto_reload = ar;
        @(posedge clk);
        bus.cmd_valid   = 1'b0;
        bus.limit       = ~lim;
        bus.auto_reload = ~ar;
    endtask

    task automatic test_reset;
        #1;
        n_total++; if (bus.count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
        n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); else n_pass++;
        n_total++; if (bus.tc_pulse !== 1'b0) $display("FAIL reset_tc got=%b exp=0", bus.tc_pulse); else n_pass++;
        @(posedge clk);
        reset = 1'b0;
        @(posedge clk);
        send(OP_STOP, 4'd0, 4'd0, 1'b0);
        send(OP_START, 4'd0, 4'd9, 1'b0);
        repeat (5) @(posedge clk);
        n_total++; if (bus.count !== 4'd5) $display("FAIL midrun_pre count got=%0d exp=5", bus.count); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (bus.count !== 4'd0) $display("FAIL midrun_reset count got=%0d exp=0", bus.count); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL midrun_reset busy got=%b exp=0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL midrun_reset done got=%b exp=0", bus.done); else n_pass++;
        n_total++; if (bus.cmd_ready !== 1'b1) $display("FAIL midrun_reset ready got=%b exp=1", bus.cmd_ready); else n_pass++;
        #1 reset = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_single_shot;
        send(OP_STOP, 4'd0, 4'd0, 1'b0);
        send(OP_START, 4'd0, 4'd3, 1'b0);
        n_total++; if (bus.count !== 4'd0 || bus.busy !== 1'b1)
            $display("FAIL shot_start count=%0d busy=%b exp count=0 busy=1", bus.count, bus.busy); else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            n_total++; if (bus.count !== 4'(i) || bus.done !== 1'b0)
                $display("FAIL shot_step%0d count=%0d done=%b exp count=%0d done=0", i, bus.count, bus.done, i); else n_pass++;
        end
        @(posedge clk);
        n_total++; if (bus.done !== 1'b1 || bus.count !== 4'd3 || bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL shot_done done=%b count=%0d ready=%b busy=%b exp 1,3,0,0",
                     bus.done, bus.count, bus.cmd_ready, bus.busy); else n_pass++;
        @(posedge clk);
        n_total++; if (bus.done !== 1'b0 || bus.count !== 4'd3 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL shot_idle done=%b count=%0d ready=%b busy=%b exp 0,3,1,0",
                     bus.done, bus.count, bus.cmd_ready, bus.busy); else n_pass++;
    endtask

    task automatic test_auto_reload;
        logic [3:0] exp_cnt [6];
        logic       exp_tc  [6];
        exp_cnt = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
        exp_tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        send(OP_STOP, 4'd0, 4'd0, 1'b0);
        send(OP_START, 4'd0, 4'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            n_total++; if (bus.count !== exp_cnt[i] || bus.tc_pulse !== exp_tc[i] || bus.done !== 1'b0)
                $display("FAIL reload_step%0d count=%0d tc=%b done=%b exp count=%0d tc=%b done=0",
                         i, bus.count, bus.tc_pulse, bus.done, exp_cnt[i], exp_tc[i]); else n_pass++;
        end
        send(OP_STOP, 4'd0, 4'd0, 1'b0);
        n_total++; if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.tc_pulse !== 1'b0)
            $display("FAIL reload_stop count=%0d busy=%b tc=%b exp 0,0,0", bus.count, bus.busy, bus.tc_pulse); else n_pass++;
    endtask

    task automatic test_pause;
        send(OP_START, 4'd0, 4'd15, 1'b0);
        repeat (4) @(posedge clk);
        n_total++; if (bus.count !== 4'd4) $display("FAIL pause_pre count=%0d exp=4", bus.count); else n_pass++;
        send(OP_PAUSE, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_total++; if (bus.count !== 4'd4 || bus.busy !== 1'b1)
                $display("FAIL pause_hold%0d count=%0d busy=%b exp count=4 busy=1", i, bus.count, bus.busy); else n_pass++;
            if (i < 2) @(posedge clk);
        end
        // Offered limit of 5 must be ignored: a re-latch would terminate at 5.
        send(OP_START, 4'd0, 4'd5, 1'b0);
        n_total++; if (bus.count !== 4'd4 || bus.busy !== 1'b1)
            $display("FAIL resume_edge count=%0d busy=%b exp count=4 busy=1", bus.count, bus.busy); else n_pass++;
        @(posedge clk);
        n_total++; if (bus.count !== 4'd5) $display("FAIL resume_5 count=%0d exp=5", bus.count); else n_pass++;
        @(posedge clk);
        n_total++; if (bus.count !== 4'd6 || bus.done !== 1'b0)
            $display("FAIL resume_6 count=%0d done=%b exp count=6 done=0", bus.count, bus.done); else n_pass++;
        send(OP_STOP, 4'd0, 4'd0, 1'b0);
        n_total++; if (bus.count !== 4'd0 || bus.busy !== 1'b0)
            $display("FAIL pause_stop count=%0d busy=%b exp 0,0", bus.count, bus.busy); else n_pass++;
    endtask

    task automatic test_load_wrap;
        logic [3:0] exp_cnt [3];
        exp_cnt = '{4'd15, 4'd0, 4'd1};
        send(OP_LOAD, 4'd14, 4'd0, 1'b0);
        n_total++; if (bus.count !== 4'd14 || bus.busy !== 1'b0)
            $display("FAIL load_idle count=%0d busy=%b exp 14,0", bus.count, bus.busy); else n_pass++;
        send(OP_START, 4'd0, 4'd1, 1'b0);
        n_total++; if (bus.count !== 4'd14) $display("FAIL load_start count=%0d exp=14", bus.count); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            n_total++; if (bus.count !== exp_cnt[i] || bus.done !== 1'b0)
                $display("FAIL wrap_step%0d count=%0d done=%b exp count=%0d done=0", i, bus.count, bus.done, exp_cnt[i]); else n_pass++;
        end
        @(posedge clk);
        n_total++; if (bus.done !== 1'b1 || bus.count !== 4'd1 || bus.tc_pulse !== 1'b0)
            $display("FAIL wrap_done done=%b count=%0d tc=%b exp 1,1,0", bus.done, bus.count, bus.tc_pulse); else n_pass++;
        @(posedge clk);
        n_total++; if (bus.done !== 1'b0 || bus.count !== 4'd1)
            $display("FAIL wrap_idle done=%b count=%0d exp 0,1", bus.done, bus.count); else n_pass++;
    endtask

    task automatic test_back_to_back;
        send(OP_STOP, 4'd0, 4'd0, 1'b0);
        send(OP_START, 4'd0, 4'd0, 1'b0);
        n_total++; if (bus.count !== 4'd0 || bus.busy !== 1'b1)
            $display("FAIL zero_start count=%0d busy=%b exp 0,1", bus.count, bus.busy); else n_pass++;
        @(posedge clk);
        n_total++; if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b0)
            $display("FAIL zero_done done=%b ready=%b exp 1,0", bus.done, bus.cmd_ready); else n_pass++;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_data  = 4'd7;
        @(posedge clk);
        n_total++; if (bus.count !== 4'd0 || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL held_in_done count=%0d ready=%b done=%b exp 0,1,0", bus.count, bus.cmd_ready, bus.done); else n_pass++;
        @(posedge clk);
        bus.cmd_valid = 1'b0;
        n_total++; if (bus.count !== 4'd7 || bus.busy !== 1'b0)
            $display("FAIL held_accept count=%0d busy=%b exp 7,0", bus.count, bus.busy); else n_pass++;
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'b00;
        bus.cmd_data    = 4'd0;
        bus.limit       = 4'd0;
        bus.auto_reload = 1'b0;
        test_reset();
        test_single_shot();
        test_auto_reload();
        test_pause();
        test_load_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
